muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the execute stage's multiply, divide and remainder operations. It replaces the single-cycle `*`, `/` and `%` paths with one shared iterative shift/add and subtract engine and holds the pipeline stalled while it runs. It accepts the same 6-bit ALU control encoding as the execute ALU. It returns a 64-bit result with RISC-V M-extension semantics.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/muldiv_fix.sv | 36 +++
 rtl/muldiv_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU control codes shared by the execute ALU and the multi-cycle mul/div sequencer,
// plus the sequencer's state and operation-class types.
package alu_pkg;

    localparam logic [5:0] ALU_ADD    = 6'd1;
    localparam logic [5:0] ALU_SUB    = 6'd2;
    localparam logic [5:0] ALU_AND    = 6'd3;
    localparam logic [5:0] ALU_OR     = 6'd4;
    localparam logic [5:0] ALU_XOR    = 6'd5;
    localparam logic [5:0] ALU_DIV    = 6'd6;
    localparam logic [5:0] ALU_DIVU   = 6'd7;
    localparam logic [5:0] ALU_REM    = 6'd8;
    localparam logic [5:0] ALU_REMU   = 6'd9;
    localparam logic [5:0] ALU_MUL    = 6'd10;
    localparam logic [5:0] ALU_MULH   = 6'd11;
    localparam logic [5:0] ALU_MULHU  = 6'd12;
    localparam logic [5:0] ALU_MULHSU = 6'd13;
    localparam logic [5:0] ALU_SLL    = 6'd14;
    localparam logic [5:0] ALU_SRL    = 6'd15;
    localparam logic [5:0] ALU_SRA    = 6'd16;
    localparam logic [5:0] ALU_SLT    = 6'd17;
    localparam logic [5:0] ALU_SLTU   = 6'd18;
    localparam logic [5:0] ALU_LUI    = 6'd19;
    localparam logic [5:0] ALU_AUIPC  = 6'd20;
    localparam logic [5:0] ALU_BEQ    = 6'd21;
    localparam logic [5:0] ALU_BNE    = 6'd22;
    localparam logic [5:0] ALU_BLT    = 6'd23;
    localparam logic [5:0] ALU_BGE    = 6'd24;
    localparam logic [5:0] ALU_BLTU   = 6'd25;
    localparam logic [5:0] ALU_BGEU   = 6'd26;
    localparam logic [5:0] ALU_JAL    = 6'd27;
    localparam logic [5:0] ALU_JALR   = 6'd28;
    localparam logic [5:0] ALU_PASS_A = 6'd29;
    localparam logic [5:0] ALU_PASS_B = 6'd30;
    localparam logic [5:0] ALU_ADDW   = 6'd31;
    localparam logic [5:0] ALU_SUBW   = 6'd32;
    localparam logic [5:0] ALU_SLLW   = 6'd33;
    localparam logic [5:0] ALU_SRLW   = 6'd34;
    localparam logic [5:0] ALU_SRAW   = 6'd35;
    localparam logic [5:0] ALU_ANDN   = 6'd36;
    localparam logic [5:0] ALU_ORN    = 6'd37;
    localparam logic [5:0] ALU_DIVW   = 6'd38;
    localparam logic [5:0] ALU_DIVUW  = 6'd39;
    localparam logic [5:0] ALU_REMW   = 6'd40;
    localparam logic [5:0] ALU_REMUW  = 6'd41;
    localparam logic [5:0] ALU_MULW   = 6'd42;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        MD_MUL_LO = 2'd0,
        MD_MUL_HI = 2'd1,
        MD_DIV    = 2'd2,
        MD_REM    = 2'd3
    } md_class_e;

    function automatic logic is_md_op(input logic [5:0] op_code);
        return ((op_code >= ALU_DIV)  && (op_code <= ALU_MULHSU)) ||
               ((op_code >= ALU_DIVW) && (op_code <= ALU_MULW));
    endfunction

endpackage

// File: rtl/muldiv_fix.sv
// Sign correction and result selection for the mul/div engine; purely combinational.
module muldiv_fix
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  md_class_e         cls_i,
    input  logic              word_i,
    input  logic              neg_res_i,
    input  logic              neg_rem_i,
    output logic [XLEN-1:0]   result_o
);

    localparam int HALF = XLEN / 2;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   sel;

    // acc_i holds the 128-bit product for multiplies, or {remainder, quotient} for divides.
    always_comb begin
        prod = neg_res_i ? -acc_i : acc_i;
        quo  = neg_res_i ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
        rem  = neg_rem_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
        case (cls_i)
            MD_MUL_HI: sel = prod[2*XLEN-1:XLEN];
            MD_DIV:    sel = quo;
            MD_REM:    sel = rem;
            default:   sel = prod[XLEN-1:0];
        endcase
        result_o = word_i ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide/remainder engine for the execute stage: one bit per cycle,
// shared shift/add and restoring-subtract datapath, pipeline stalled while it runs.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int         HALF   = XLEN / 2;
    localparam logic [6:0] N_FULL = 7'(XLEN);
    localparam logic [6:0] N_WORD = 7'(HALF);

    md_state_e         state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   op1_q, op1_d;
    logic [XLEN-1:0]   op2_q, op2_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    md_class_e         cls_q, cls_d;
    logic              word_q, word_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;

    logic              md_op, accept, word, sgn_a, sgn_b, is_div;
    logic              b_zero, ovf, special, neg_a, neg_b;
    md_class_e         cls;
    logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b;

    logic [2*XLEN-1:0] mul_step, div_step;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_sub;
    logic              ge;
    logic [XLEN-1:0]   fix_result;

    // Request decode and operand preparation.
    always_comb begin
        md_op  = is_md_op(op);
        accept = start & md_op & ~flush & ((state_q == MD_IDLE) | (state_q == MD_DONE));
        word   = op[5];
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        cls    = MD_MUL_LO;
        case (op)
            ALU_DIV, ALU_DIVW:   begin cls = MD_DIV; sgn_a = 1'b1; sgn_b = 1'b1; end
            ALU_DIVU, ALU_DIVUW: cls = MD_DIV;
            ALU_REM, ALU_REMW:   begin cls = MD_REM; sgn_a = 1'b1; sgn_b = 1'b1; end
            ALU_REMU, ALU_REMUW: cls = MD_REM;
            ALU_MULH:            begin cls = MD_MUL_HI; sgn_a = 1'b1; sgn_b = 1'b1; end
            ALU_MULHU:           cls = MD_MUL_HI;
            ALU_MULHSU:          begin cls = MD_MUL_HI; sgn_a = 1'b1; end
            default:             cls = MD_MUL_LO;
        endcase
        is_div = (cls == MD_DIV) | (cls == MD_REM);

        if (word) begin
            ext_a = sgn_a ? {{HALF{src_a[HALF-1]}}, src_a[HALF-1:0]} : {{HALF{1'b0}}, src_a[HALF-1:0]};
            ext_b = sgn_b ? {{HALF{src_b[HALF-1]}}, src_b[HALF-1:0]} : {{HALF{1'b0}}, src_b[HALF-1:0]};
        end else begin
            ext_a = src_a;
            ext_b = src_b;
        end
        neg_a = sgn_a & ext_a[XLEN-1];
        neg_b = sgn_b & ext_b[XLEN-1];
        mag_a = neg_a ? -ext_a : ext_a;
        mag_b = neg_b ? -ext_b : ext_b;

        b_zero  = word ? (src_b[HALF-1:0] == '0) : (src_b == '0);
        ovf     = sgn_b & (word ? ((src_a[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) & (&src_b[HALF-1:0]))
                                : ((src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b)));
        special = is_div & (b_zero | ovf);
    end

    // One iteration step; op1 is consumed MSB-first, so W operands are pre-shifted into the top half.
    always_comb begin
        mul_step = {acc_q[2*XLEN-2:0], 1'b0} + (op1_q[XLEN-1] ? {{XLEN{1'b0}}, op2_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], op1_q[XLEN-1]};
        ge       = rem_sh >= {1'b0, op2_q};
        rem_sub  = rem_sh[XLEN-1:0] - op2_q;
        div_step = {ge ? rem_sub : rem_sh[XLEN-1:0], acc_q[XLEN-2:0], ge};
    end

    muldiv_fix #(
        .XLEN(XLEN)
    ) u_fix (
        .acc_i     (acc_q),
        .cls_i     (cls_q),
        .word_i    (word_q),
        .neg_res_i (neg_res_q),
        .neg_rem_i (neg_rem_q),
        .result_o  (fix_result)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        acc_d     = acc_q;
        result_d  = result_q;
        cls_d     = cls_q;
        word_d    = word_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (accept) begin
                    cls_d  = cls;
                    word_d = word;
                    op1_d  = word ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
                    op2_d  = mag_b;
                    if (special) begin
                        // Preload {remainder, quotient} so FIX emits the architected special result.
                        acc_d     = b_zero ? {ext_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, ext_a};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = MD_FIX;
                    end else begin
                        acc_d     = '0;
                        neg_res_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        cnt_d     = word ? N_WORD : N_FULL;
                        state_d   = MD_CALC;
                    end
                end else if (state_q == MD_DONE) begin
                    state_d = MD_IDLE;
                end
            end
            MD_CALC: begin
                acc_d = ((cls_q == MD_DIV) | (cls_q == MD_REM)) ? div_step : mul_step;
                op1_d = {op1_q[XLEN-2:0], 1'b0};
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                result_d = fix_result;
                state_d  = MD_DONE;
            end
            default: state_d = MD_IDLE;
        endcase

        if (flush) begin
            state_d  = MD_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            cls_q     <= MD_MUL_LO;
            word_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            cls_q     <= cls_d;
            word_q    <= word_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy   = (state_q == MD_CALC) | (state_q == MD_FIX);
    assign done   = (state_q == MD_DONE);
    assign stall  = busy | accept;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, results, stall/done shape,
// special cases, flush, back-to-back issue and mid-operation reset.
module tb_muldiv_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [5:0]  op;
    logic [63:0] src_a, src_b;
    logic        stall, busy, done;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request, then count cycles after the start cycle until done (bounded).
    task automatic run_op(input string tag, input logic [5:0] o, input logic [63:0] a,
                          input logic [63:0] b, input int exp_n, input logic [63:0] exp_r);
        int n;
        bit gap;
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        check_eq({tag, ".stall_req"}, 64'(stall), 64'd1);
        n = 0;
        gap = 1'b0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (!done && !stall) gap = 1'b1;
        end while (!done && n < 200);
        check_eq({tag, ".latency"}, 64'(n), 64'(exp_n));
        check_eq({tag, ".result"}, result, exp_r);
        check_eq({tag, ".stall_run"}, 64'(gap), 64'd0);
        check_eq({tag, ".stall_done"}, 64'(stall), 64'd0);
        $display("%s: op=%0d a=%h b=%h result=%h cycles=%0d", tag, o, a, b, result, n);
        @(posedge clk); #1;
        check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        check_eq("rst.stall", 64'(stall), 64'd0);
        check_eq("rst.result", result, 64'd0);
        $display("reset: busy=%0d done=%0d stall=%0d result=%h", busy, done, stall, result);

        run_op("mul",     ALU_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 66, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu",   ALU_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 66, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhsu",  ALU_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulh",    ALU_MULH,   64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 66, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulw",    ALU_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 34, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("divw_ovf", ALU_DIVW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'hFFFF_FFFF_8000_0000);
        run_op("div_ovf", ALU_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'h8000_0000_0000_0000);
        run_op("rem",     ALU_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div",     ALU_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("remw_dz", ALU_REMW,   64'h0000_0001_FFFF_FFF9, 64'h0000_0001_0000_0000, 2, 64'hFFFF_FFFF_FFFF_FFF9);
        run_op("divu_dz", ALU_DIVU,   64'd5, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFFF);

        // A non-mul/div code must be ignored.
        op = ALU_ADD; src_a = 64'd1; src_b = 64'd2; start = 1'b1;
        #1 check_eq("nonmd.stall", 64'(stall), 64'd0);
        @(posedge clk); #1 start = 1'b0;
        check_eq("nonmd.busy", 64'(busy), 64'd0);
        $display("nonmd: op=%0d busy=%0d", ALU_ADD, busy);

        // Flush at cycle +10 of a div: no done, result keeps the previous value.
        op = ALU_DIV; src_a = 64'd100; src_b = 64'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check_eq("flush.busy", 64'(busy), 64'd0);
        check_eq("flush.stall", 64'(stall), 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check_eq("flush.no_done", 64'(seen), 64'd0);
        check_eq("flush.result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        $display("flush: done_seen=%0d result=%h", seen, result);
        run_op("div_after_flush", ALU_DIV, 64'd100, 64'd7, 66, 64'd14);

        // Back-to-back remuw with start held: second request accepted in the DONE cycle.
        op = ALU_REMUW; src_a = 64'd10; src_b = 64'd3; start = 1'b1;
        @(posedge clk); #1;
        src_a = 64'd9; src_b = 64'd4;
        n = 1;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("b2b1.latency", 64'(n), 64'd34);
        check_eq("b2b1.result", result, 64'd1);
        check_eq("b2b1.stall", 64'(stall), 64'd1);
        $display("b2b1: op=%0d a=10 b=3 result=%h cycles=%0d", ALU_REMUW, result, n);
        @(posedge clk); #1 start = 1'b0;
        check_eq("b2b2.busy", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("b2b2.latency", 64'(n), 64'd34);
        check_eq("b2b2.result", result, 64'd1);
        $display("b2b2: op=%0d a=9 b=4 result=%h cycles=%0d", ALU_REMUW, result, n);

        // Reset at cycle +20 of a mul.
        op = ALU_MUL; src_a = 64'd3; src_b = 64'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        check_eq("midrst.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_eq("midrst.busy", 64'(busy), 64'd0);
        check_eq("midrst.done", 64'(done), 64'd0);
        check_eq("midrst.stall", 64'(stall), 64'd0);
        check_eq("midrst.result", result, 64'd0);
        $display("midrst: busy=%0d done=%0d stall=%0d result=%h", busy, done, stall, result);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
